// File: rtl/sdf_fft_ctrl_if.sv
// Handshake and steering bundle between the SDF FFT sequencer and its stream/datapath.
// The master drives the sample stream; the slave (sequencer) returns framing and stage controls.
`timescale 1ns/1ps
interface sdf_fft_ctrl_if #(
    parameter int LOG2N = 3
);
    logic                           in_valid;
    logic                           in_sop;
    logic                           flush;
    logic                           in_ready;
    logic                           ce;
    logic [LOG2N-1:0]               sel;
    logic [LOG2N*(LOG2N-1)-1:0]     tw_addr;
    logic                           out_valid;
    logic                           out_sop;
    logic                           err;

    modport master (
        output in_valid, in_sop, flush,
        input  in_ready, ce, sel, tw_addr, out_valid, out_sop, err
    );

    modport slave (
        input  in_valid, in_sop, flush,
        output in_ready, ce, sel, tw_addr, out_valid, out_sop, err
    );
endinterface

// File: rtl/sdf_fft_ctrl.sv
// Sequencer for a radix-2 single-path delay-feedback FFT: frame tracking, per-stage
// select/twiddle decode, pipeline fill/run framing and an end-of-stream flush.
`timescale 1ns/1ps
module sdf_fft_ctrl #(
    parameter int LOG2N = 3
) (
    input  logic              clk,
    input  logic              clear,
    sdf_fft_ctrl_if.slave     bus
);
    localparam int N    = 1 << LOG2N;
    localparam int TW_W = LOG2N - 1;
    localparam logic [LOG2N-1:0] CNT_LAST  = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] PRIME_END = LOG2N'(N - 2);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t           state_reg, state_next;
    logic [LOG2N-1:0] cnt_reg, cnt_next;
    logic [LOG2N-1:0] prime_reg, prime_next;
    logic             err_reg, err_next;
    logic             ce_c, ready_c, ov_c, at_zero;
    logic [LOG2N-1:0] sel_c;
    logic [LOG2N*TW_W-1:0] tw_c;

    assign at_zero = (cnt_reg == '0);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            prime_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            prime_reg <= prime_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        prime_next = prime_reg;
        err_next   = err_reg;
        ce_c       = 1'b0;
        ready_c    = 1'b1;
        ov_c       = 1'b0;
        case (state_reg)
            IDLE: begin
                ce_c = bus.in_valid & bus.in_sop;
                if (bus.in_valid && !bus.in_sop)
                    err_next = 1'b1;
                if (ce_c) begin
                    cnt_next   = cnt_reg + 1'b1;
                    prime_next = LOG2N'(1);
                    state_next = FILL;
                end
            end
            FILL, RUN: begin
                ce_c = bus.in_valid;
                ov_c = (state_reg == RUN) & bus.in_valid;
                if (bus.in_valid) begin
                    // sop must coincide exactly with the frame boundary; mismatches are
                    // flagged but the sample is still taken (no resync)
                    if (bus.in_sop != at_zero)
                        err_next = 1'b1;
                    if (bus.flush)
                        err_next = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                    if (state_reg == FILL) begin
                        prime_next = prime_reg + 1'b1;
                        if (prime_reg == PRIME_END)
                            state_next = RUN;
                    end
                end else if (bus.flush) begin
                    if (at_zero) begin
                        state_next = FLUSH;
                        prime_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            FLUSH: begin
                ce_c       = 1'b1;
                ready_c    = 1'b0;
                ov_c       = 1'b1;
                cnt_next   = cnt_reg + 1'b1;
                prime_next = prime_reg + 1'b1;
                if (prime_reg == PRIME_END) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    prime_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage k sees the frame delayed by the sum of all upstream feedback delays.
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_stage
        localparam logic [LOG2N-1:0] OFF  = LOG2N'(N - (N >> gi));
        localparam logic [LOG2N-1:0] MASK = LOG2N'((N >> (gi + 1)) - 1);
        logic [LOG2N-1:0] m;
        assign m                        = cnt_reg - OFF;
        assign sel_c[gi]                = m[LOG2N-1-gi];
        assign tw_c[gi*TW_W +: TW_W]    = TW_W'((m & MASK) << gi);
    end

    assign bus.ce        = ce_c & clear;
    assign bus.in_ready  = ready_c;
    assign bus.out_valid = ov_c;
    assign bus.out_sop   = ov_c & (cnt_reg == CNT_LAST);
    assign bus.err       = err_reg;
    assign bus.sel       = sel_c;
    assign bus.tw_addr   = tw_c;
endmodule

// File: tb/tb_sdf_fft_ctrl.sv
// Self-checking bench for sdf_fft_ctrl at N=8: expected per-cycle controls are queued
// when stimulus is driven and compared when the cycle's outputs settle.
`timescale 1ns/1ps
module tb_sdf_fft_ctrl;
    logic clk = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    sdf_fft_ctrl_if #(.LOG2N(3)) bus ();
    sdf_fft_ctrl #(.LOG2N(3)) dut (.clk(clk), .clear(clear), .bus(bus));

    typedef struct {
        string      tag;
        logic       ce, ready, ov, osop, err;
        logic [2:0] sel;
        logic [5:0] tw;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    // reference state: 0 idle, 1 fill, 2 run, 3 flush
    int mst = 0, mcnt = 0, mprime = 0;
    bit merr = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_sel(input int c);
        return 3'((c >= 4 ? 1 : 0) | (((c / 2) % 2) << 1) | ((c % 2) << 2));
    endfunction

    function automatic logic [5:0] exp_tw(input int c);
        return 6'((c % 4) | (((c % 2) * 2) << 2));
    endfunction

    task automatic cycle(input string tag, input bit iv, input bit sop, input bit fl);
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid = iv;
        bus.in_sop   = sop;
        bus.flush    = fl;
        e.tag   = tag;
        e.ready = 1'b1;
        e.ov    = 1'b0;
        case (mst)
            0:       e.ce = iv & sop;
            1, 2: begin
                e.ce = iv;
                e.ov = (mst == 2) && iv;
            end
            default: begin
                e.ce = 1'b1; e.ready = 1'b0; e.ov = 1'b1;
            end
        endcase
        e.osop = e.ov && (mcnt == 7);
        e.err  = merr;
        e.sel  = exp_sel(mcnt);
        e.tw   = exp_tw(mcnt);
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        $display("%0t %s iv=%0b sop=%0b fl=%0b -> ce=%0b rdy=%0b sel=%03b tw=%02h ov=%0b osop=%0b err=%0b",
                 $time, e.tag, iv, sop, fl, bus.ce, bus.in_ready, bus.sel, bus.tw_addr,
                 bus.out_valid, bus.out_sop, bus.err);
        check_val({e.tag, ".ce"},    32'(bus.ce),        32'(e.ce));
        check_val({e.tag, ".rdy"},   32'(bus.in_ready),  32'(e.ready));
        check_val({e.tag, ".sel"},   32'(bus.sel),       32'(e.sel));
        check_val({e.tag, ".tw"},    32'(bus.tw_addr),   32'(e.tw));
        check_val({e.tag, ".ov"},    32'(bus.out_valid), 32'(e.ov));
        check_val({e.tag, ".osop"},  32'(bus.out_sop),   32'(e.osop));
        check_val({e.tag, ".err"},   32'(bus.err),       32'(e.err));

        case (mst)
            0: begin
                if (iv && sop) begin mcnt = 1; mprime = 1; mst = 1; end
                else if (iv) merr = 1;
            end
            1, 2: begin
                if (iv) begin
                    if (sop && mcnt != 0) merr = 1;
                    if (!sop && mcnt == 0) merr = 1;
                    if (fl) merr = 1;
                    mcnt = (mcnt + 1) % 8;
                    if (mst == 1) begin
                        mprime++;
                        if (mprime == 7) mst = 2;
                    end
                end else if (fl) begin
                    if (mcnt == 0) begin mst = 3; mprime = 0; end
                    else merr = 1;
                end
            end
            default: begin
                mprime++;
                mcnt++;
                if (mprime == 7) begin mst = 0; mcnt = 0; mprime = 0; end
            end
        endcase
    endtask

    task automatic frame(input string tag, input int sop_extra, input int gap_at, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) cycle({tag, "_gap"}, 1'b0, 1'b0, 1'b0);
            cycle(tag, 1'b1, (i == 0) || (i == sop_extra), 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".ce"},   32'(bus.ce),        32'd0);
        check_val({tag, ".rdy"},  32'(bus.in_ready),  32'd1);
        check_val({tag, ".sel"},  32'(bus.sel),       32'd0);
        check_val({tag, ".tw"},   32'(bus.tw_addr),   32'd0);
        check_val({tag, ".ov"},   32'(bus.out_valid), 32'd0);
        check_val({tag, ".osop"}, 32'(bus.out_sop),   32'd0);
        check_val({tag, ".err"},  32'(bus.err),       32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        clear = 1'b1;

        cycle("idle", 1'b0, 1'b0, 1'b0);
        cycle("idle_flush", 1'b0, 1'b0, 1'b1);
        cycle("idle", 1'b0, 1'b0, 1'b0);

        frame("frmA", -1, -1, 0);
        frame("frmB", -1, -1, 0);
        cycle("flush_req", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle("drain", i[0], 1'b0, 1'b0);
        cycle("post_flush", 1'b0, 1'b0, 1'b0);
        cycle("post_flush", 1'b0, 1'b0, 1'b0);

        frame("frmC", -1, 5, 3);
        frame("frmD", 3, -1, 0);
        cycle("frmE", 1'b1, 1'b1, 1'b0);
        cycle("frmE", 1'b1, 1'b0, 1'b0);
        cycle("flush_mid", 1'b0, 1'b0, 1'b1);
        cycle("frmE", 1'b1, 1'b0, 1'b0);
        cycle("frmE", 1'b1, 1'b0, 1'b0);

        // asynchronous clear in the middle of a running frame
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b0;
        #2 clear = 1'b0;
        #1 check_reset_outputs("async_clr");
        bus.in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        mst = 0; mcnt = 0; mprime = 0; merr = 0;

        cycle("idle_nosop", 1'b1, 1'b0, 1'b0);
        cycle("idle", 1'b0, 1'b0, 1'b0);
        frame("frmF", -1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
